// File: rtl/meteor_line_fetch.sv
// Per-scanline sprite row fetcher and pixel hit tester for the meteor/coin ROM.
// Optional overlap detection is enabled by defining METEOR_OVERLAP_EN.
module meteor_line_fetch #(
  parameter int N_OBJ = 4,
  parameter int X_W   = 10,
  parameter int Y_W   = 10,
  parameter int IDX_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   line_start,
  input  logic [Y_W-1:0]         next_line,
  input  logic [X_W-1:0]         hcount,
  input  logic                   active,
  input  logic [N_OBJ-1:0]       obj_valid,
  input  logic [N_OBJ*X_W-1:0]   obj_x,
  input  logic [N_OBJ*Y_W-1:0]   obj_y,
  input  logic [N_OBJ*2-1:0]     obj_sprite,
  output logic [3:0]             rom_y,
  output logic [1:0]             rom_sprite,
  input  logic [15:0]            rom_bits,
  output logic                   fetch_busy,
  output logic                   pixel_on,
  output logic [IDX_W-1:0]       pixel_obj,
  output logic                   overlap
);

  typedef enum logic [0:0] {IDLE = 1'b0, FETCH = 1'b1} state_t;

  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(N_OBJ - 1);

  state_t           state_r, state_nxt_s;
  logic [Y_W-1:0]   line_q_r;
  logic [IDX_W-1:0] k_r;
  logic             fetch_busy_r;
  logic [15:0]      shadow_row_r [N_OBJ];
  logic [X_W-1:0]   shadow_x_r   [N_OBJ];
  logic [15:0]      disp_row_r   [N_OBJ];
  logic [X_W-1:0]   disp_x_r     [N_OBJ];

  logic             sel_valid_s;
  logic [X_W-1:0]   sel_x_s;
  logic [Y_W-1:0]   sel_y_s;
  logic [1:0]       sel_sprite_s;
  logic [Y_W-1:0]   dy_s;
  logic             in_range_s;
  logic [15:0]      fetch_row_s;
  logic             wr_s;
  logic             last_s;
  logic [3:0]       rom_y_s;
  logic [1:0]       rom_sprite_s;

  logic [X_W-1:0]   dx_s [N_OBJ];
  logic [N_OBJ-1:0] hit_s;
  logic [IDX_W-1:0] win_s;

  logic             pixel_on_r;
  logic [IDX_W-1:0] pixel_obj_r;

  // Select the object fields of the slot currently being fetched
  always_comb begin
    sel_valid_s  = 1'b0;
    sel_x_s      = '0;
    sel_y_s      = '0;
    sel_sprite_s = 2'b00;
    for (int i = 0; i < N_OBJ; i++) begin
      sel_valid_s  = (k_r == IDX_W'(i)) ? obj_valid[i]            : sel_valid_s;
      sel_x_s      = (k_r == IDX_W'(i)) ? obj_x[i*X_W +: X_W]     : sel_x_s;
      sel_y_s      = (k_r == IDX_W'(i)) ? obj_y[i*Y_W +: Y_W]     : sel_y_s;
      sel_sprite_s = (k_r == IDX_W'(i)) ? obj_sprite[i*2 +: 2]    : sel_sprite_s;
    end
  end

  // Modular subtraction lets objects straddling the line wrap still match
  assign dy_s        = line_q_r - sel_y_s;
  assign in_range_s  = sel_valid_s & (dy_s < Y_W'(16));
  assign fetch_row_s = in_range_s ? rom_bits : 16'h0000;

  // Next-state and ROM address decode
  always_comb begin
    state_nxt_s  = state_r;
    last_s       = 1'b0;
    wr_s         = 1'b0;
    rom_y_s      = 4'd0;
    rom_sprite_s = 2'd0;
    case (state_r)
      IDLE: begin
        if (line_start) begin
          state_nxt_s = FETCH;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FETCH: begin
        rom_y_s      = dy_s[3:0];
        rom_sprite_s = sel_sprite_s;
        if (line_start) begin
          state_nxt_s = FETCH;
        end else if (k_r == K_LAST) begin
          state_nxt_s = IDLE;
          wr_s        = 1'b1;
          last_s      = 1'b1;
        end else begin
          state_nxt_s = FETCH;
          wr_s        = 1'b1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  assign rom_y      = rom_y_s;
  assign rom_sprite = rom_sprite_s;

  // State, line latch and slot counter; a new line_start always restarts at slot 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      line_q_r     <= '0;
      k_r          <= '0;
      fetch_busy_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      fetch_busy_r <= (state_nxt_s == FETCH);
      if (line_start) begin
        line_q_r <= next_line;
        k_r      <= '0;
      end else if (wr_s) begin
        k_r <= last_s ? '0 : k_r + IDX_W'(1);
      end
    end
  end

  assign fetch_busy = fetch_busy_r;

  // Shadow fill; the last slot's row goes straight into the display copy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_OBJ; i++) begin
        shadow_row_r[i] <= 16'h0000;
        shadow_x_r[i]   <= '0;
        disp_row_r[i]   <= 16'h0000;
        disp_x_r[i]     <= '0;
      end
    end else if (wr_s) begin
      for (int i = 0; i < N_OBJ; i++) begin
        if (k_r == IDX_W'(i)) begin
          shadow_row_r[i] <= fetch_row_s;
          shadow_x_r[i]   <= sel_x_s;
        end
        if (last_s) begin
          disp_row_r[i] <= (k_r == IDX_W'(i)) ? fetch_row_s : shadow_row_r[i];
          disp_x_r[i]   <= (k_r == IDX_W'(i)) ? sel_x_s     : shadow_x_r[i];
        end
      end
    end
  end

  // Per-slot hit test against the display buffer; row MSB is the leftmost pixel
  always_comb begin
    hit_s = '0;
    for (int i = 0; i < N_OBJ; i++) begin
      dx_s[i]  = hcount - disp_x_r[i];
      hit_s[i] = active & (dx_s[i] < X_W'(16)) & disp_row_r[i][4'd15 - dx_s[i][3:0]];
    end
  end

  // Lowest hitting index wins
  always_comb begin
    win_s = '0;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      win_s = hit_s[i] ? IDX_W'(i) : win_s;
    end
  end

  // Pixel output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_on_r  <= 1'b0;
      pixel_obj_r <= '0;
    end else begin
      pixel_on_r  <= |hit_s;
      pixel_obj_r <= win_s;
    end
  end

  assign pixel_on  = pixel_on_r;
  assign pixel_obj = pixel_obj_r;

`ifdef METEOR_OVERLAP_EN
  logic [3:0] hit_cnt_s;
  logic       overlap_r;

  // Count simultaneous hits
  always_comb begin
    hit_cnt_s = 4'd0;
    for (int i = 0; i < N_OBJ; i++) begin
      hit_cnt_s = hit_cnt_s + {3'b000, hit_s[i]};
    end
  end

  // Overlap flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overlap_r <= 1'b0;
    end else begin
      overlap_r <= (hit_cnt_s > 4'd1);
    end
  end

  assign overlap = overlap_r;
`else
  assign overlap = 1'b0;
`endif

endmodule

// File: tb/tb_meteor_line_fetch.sv
// Directed scoreboard bench for meteor_line_fetch (N_OBJ=4, X_W=Y_W=10).
module tb_meteor_line_fetch;

  localparam int N_OBJ = 4;
  localparam int X_W   = 10;
  localparam int Y_W   = 10;
  localparam int IDX_W = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 line_start;
  logic [Y_W-1:0]       next_line;
  logic [X_W-1:0]       hcount;
  logic                 active;
  logic [N_OBJ-1:0]     obj_valid;
  logic [N_OBJ*X_W-1:0] obj_x;
  logic [N_OBJ*Y_W-1:0] obj_y;
  logic [N_OBJ*2-1:0]   obj_sprite;
  logic [3:0]           rom_y;
  logic [1:0]           rom_sprite;
  logic [15:0]          rom_bits;
  logic                 fetch_busy;
  logic                 pixel_on;
  logic [IDX_W-1:0]     pixel_obj;
  logic                 overlap;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cnt;
  logic [3:0]     sb_q [$];
  logic [15:0]    ex_row [N_OBJ];
  logic [X_W-1:0] ex_x   [N_OBJ];
  logic [3:0]     rec_rom_y [8];

  always #5 clk = ~clk;

  meteor_line_fetch #(.N_OBJ(N_OBJ), .X_W(X_W), .Y_W(Y_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .line_start(line_start), .next_line(next_line),
    .hcount(hcount), .active(active), .obj_valid(obj_valid), .obj_x(obj_x),
    .obj_y(obj_y), .obj_sprite(obj_sprite), .rom_y(rom_y), .rom_sprite(rom_sprite),
    .rom_bits(rom_bits), .fetch_busy(fetch_busy), .pixel_on(pixel_on),
    .pixel_obj(pixel_obj), .overlap(overlap)
  );

  // Coin rows 2, 3, 7 hand-derived from the expected hit columns
  function automatic logic [15:0] rom_fn(input logic [1:0] s, input logic [3:0] y);
    logic [15:0] r;
    r = 16'hF00F ^ {10'h000, s, y};
    if (s == 2'd3 && y == 4'd2) r = 16'h0380;
    if (s == 2'd3 && y == 4'd3) r = 16'h06C0;
    if (s == 2'd3 && y == 4'd7) r = 16'h0C60;
    return r;
  endfunction

  assign rom_bits = rom_fn(rom_sprite, rom_y);

  // Expected {pixel_on, pixel_obj, overlap} for one pixel
  function automatic logic [3:0] model(input int h, input logic act);
    logic [X_W-1:0]   dx;
    logic             on;
    logic [IDX_W-1:0] obj;
    int               cnt;
    logic             ov;
    on = 1'b0; obj = '0; cnt = 0; ov = 1'b0;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      dx = X_W'(h) - ex_x[i];
      if (act && dx < 10'd16 && ex_row[i][15 - int'(dx[3:0])]) begin
        on = 1'b1; obj = IDX_W'(i); cnt++;
      end
    end
`ifdef METEOR_OVERLAP_EN
    ov = (cnt >= 2);
`endif
    return {on, obj, ov};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_slot(input int i, input logic v, input logic [X_W-1:0] x,
                          input logic [Y_W-1:0] y, input logic [1:0] s);
    obj_valid[i]          = v;
    obj_x[i*X_W +: X_W]   = x;
    obj_y[i*Y_W +: Y_W]   = y;
    obj_sprite[i*2 +: 2]  = s;
  endtask

  task automatic clear_model();
    for (int i = 0; i < N_OBJ; i++) begin
      ex_row[i] = 16'h0000;
      ex_x[i]   = '0;
    end
  endtask

  // Count busy cycles (bounded) and record rom_y per fetch cycle
  task automatic count_busy(input string tag);
    busy_cnt = 0;
    while (fetch_busy === 1'b1 && busy_cnt < 20) begin
      rec_rom_y[busy_cnt[2:0]] = rom_y;
      busy_cnt++;
      step();
    end
    chk(tag, busy_cnt, N_OBJ);
  endtask

  task automatic do_fetch(input logic [Y_W-1:0] nl);
    line_start = 1'b1; next_line = nl;
    step();
    line_start = 1'b0;
    chk("busy_rise", fetch_busy, 1'b1);
    count_busy("busy_len");
  endtask

  task automatic scan(input int lo, input int hi, input int skip);
    logic [3:0] exp;
    for (int h = lo; h <= hi; h++) begin
      hcount = X_W'(h);
      active = (h != skip);
      sb_q.push_back(model(h, active));
      step();
      exp = sb_q.pop_front();
      chk($sformatf("pix h=%0d", h), {pixel_on, pixel_obj, overlap}, exp);
    end
    active = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; line_start = 1'b0; next_line = '0; hcount = '0; active = 1'b0;
    obj_valid = '0; obj_x = '0; obj_y = '0; obj_sprite = '0;
    clear_model();
    step(); step();
    chk("rst_busy", fetch_busy, 1'b0);
    chk("rst_pix", {pixel_on, pixel_obj, overlap}, 4'h0);
    chk("rst_rom", {rom_y, rom_sprite}, 6'h00);
    rst_n = 1'b1;
    step();

    // Basic row lookup
    set_slot(0, 1'b1, 10'd100, 10'd50, 2'd3);
    do_fetch(10'd52);
    chk("basic_rom_y", rec_rom_y[0], 4'd2);
    ex_x[0] = 10'd100; ex_row[0] = 16'h0380;
    scan(95, 125, -1);

    // Vertical wrap
    set_slot(0, 1'b0, 10'd100, 10'd50, 2'd3);
    set_slot(1, 1'b1, 10'd0, 10'd1020, 2'd3);
    do_fetch(10'd3);
    chk("wrap_rom_y", rec_rom_y[1], 4'd7);
    clear_model();
    ex_x[1] = 10'd0; ex_row[1] = 16'h0C60;
    scan(0, 20, -1);
    scan(1018, 1023, -1);

    // Out of range and invalid slot
    set_slot(0, 1'b1, 10'd100, 10'd50, 2'd3);
    set_slot(1, 1'b0, 10'd100, 10'd66, 2'd3);
    do_fetch(10'd66);
    clear_model();
    scan(95, 125, -1);

    // Priority and overlap, with one inactive pixel inside the sprite
    set_slot(0, 1'b1, 10'd100, 10'd50, 2'd3);
    set_slot(1, 1'b0, 10'd0, 10'd0, 2'd0);
    set_slot(2, 1'b1, 10'd100, 10'd50, 2'd3);
    do_fetch(10'd52);
    clear_model();
    ex_x[0] = 10'd100; ex_row[0] = 16'h0380;
    ex_x[2] = 10'd100; ex_row[2] = 16'h0380;
    scan(100, 112, 107);

    // Restart at fetch cycle 2
    set_slot(2, 1'b0, 10'd0, 10'd0, 2'd0);
    line_start = 1'b1; next_line = 10'd52;
    step();
    line_start = 1'b0;
    step(); step();
    line_start = 1'b1; next_line = 10'd53;
    step();
    line_start = 1'b0;
    count_busy("restart_len");
    chk("restart_rom_y", rec_rom_y[0], 4'd3);
    clear_model();
    ex_x[0] = 10'd100; ex_row[0] = 16'h06C0;
    scan(98, 115, -1);

    // Reset mid-fetch while a sprite pixel is being shown
    hcount = 10'd106; active = 1'b1;
    line_start = 1'b1; next_line = 10'd52;
    step();
    line_start = 1'b0;
    step();
    chk("pre_rst_pix", pixel_on, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", fetch_busy, 1'b0);
    chk("mid_rst_pix", {pixel_on, pixel_obj, overlap}, 4'h0);
    active = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    clear_model();
    scan(98, 115, -1);
    do_fetch(10'd52);
    ex_x[0] = 10'd100; ex_row[0] = 16'h0380;
    scan(98, 115, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
